// File: rtl/nth_prime_if.sv
// Handshake and result bus for nth_prime_engine.
// The sequencer drives start/n; the engine drives the run status and results.
interface nth_prime_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 16
);
    logic             start;
    logic [CW-1:0]    n;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    logic             error;

    modport master (output start, n, input result, count, busy, done, error);
    modport slave  (input start, n, output result, count, busy, done, error);
endinterface

// File: rtl/nth_prime_engine.sv
// Runtime-programmable n-th prime finder.
// Uses trial division by odd divisors, with a bit-serial restoring remainder.
module nth_prime_engine #(
    parameter int WIDTH = 32,
    parameter int CW    = 16
) (
    input  logic        clk,
    input  logic        rst,
    nth_prime_if.slave  bus
);
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, NEXT, TEST, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    n_lat;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] result_q;
    logic [BW-1:0]    bit_cnt;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    // d*d is formed at double width so the bound test can never wrap
    logic [2*WIDTH-1:0] dsq;
    logic               d_exceeds;
    logic [WIDTH:0]     c_next;
    logic [WIDTH:0]     trial;
    logic               ge;
    logic [WIDTH-1:0]   rem_nx;
    logic [CW-1:0]      cnt_inc;
    logic               last_bit;

    assign dsq       = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
    assign d_exceeds = dsq > {{WIDTH{1'b0}}, c};
    assign c_next    = (c == WIDTH'(2)) ? {1'b0, c} + (WIDTH+1)'(1)
                                        : {1'b0, c} + (WIDTH+1)'(2);
    assign trial     = {rem, sh[WIDTH-1]};
    assign ge        = trial >= {1'b0, d};
    assign rem_nx    = ge ? WIDTH'(trial - {1'b0, d}) : trial[WIDTH-1:0];
    assign cnt_inc   = count_q + CW'(1);
    assign last_bit  = bit_cnt == BW'(WIDTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n_lat    <= '0;
            count_q  <= '0;
            c        <= '0;
            d        <= '0;
            rem      <= '0;
            sh       <= '0;
            result_q <= '0;
            bit_cnt  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        n_lat    <= bus.n;
                        result_q <= '0;
                        count_q  <= '0;
                        done_q   <= 1'b0;
                        error_q  <= 1'b0;
                        if (bus.n == '0) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            busy_q <= 1'b1;
                            c      <= WIDTH'(2);
                            d      <= WIDTH'(3);
                            state  <= TEST;
                        end
                    end
                end
                TEST: begin
                    // result tracks the latest prime so an overflow reports it
                    if (c == WIDTH'(2) || d_exceeds) begin
                        count_q  <= cnt_inc;
                        result_q <= c;
                        if (cnt_inc == n_lat) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= DONE;
                        end else begin
                            state <= NEXT;
                        end
                    end else begin
                        rem     <= '0;
                        sh      <= c;
                        bit_cnt <= '0;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    rem     <= rem_nx;
                    sh      <= sh << 1;
                    bit_cnt <= bit_cnt + BW'(1);
                    if (last_bit) begin
                        if (rem_nx == '0) begin
                            state <= NEXT;
                        end else begin
                            d     <= d + WIDTH'(2);
                            state <= TEST;
                        end
                    end
                end
                NEXT: begin
                    if (c_next[WIDTH]) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= DONE;
                    end else begin
                        c     <= c_next[WIDTH-1:0];
                        d     <= WIDTH'(3);
                        state <= TEST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.count  = count_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = error_q;
endmodule

// File: doc/nth_prime_engine.md
Name: nth_prime_engine

Overview:
- Self-contained, runtime-programmable successor to the fixed "10001st prime" solver.
- Returns the n-th prime for any n supplied at start time, using a built-in trial-division core: odd divisors only, bit-serial remainder.
- Adds a start/busy/done handshake, restart without reset, an overflow error and a live prime count.
- Sits beside the other solver blocks and is driven by a top-level sequencer or testbench.

Parameters:
- WIDTH, 32, width of candidates, divisors and result.
- CW, 16, width of the n input and the count output.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE state.
- n  input  CW  index of the wanted prime (1 -> 2); latched on accepted start.
- result  output  WIDTH  n-th prime when done && !error; last prime found on overflow.
- count  output  CW  number of primes found so far in the current run.
- busy  output  1  high from the cycle after an accepted start until completion.
- done  output  1  level; held until the next accepted start.
- error  output  1  level; valid when done; held until the next accepted start.

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - result=0, count=0, busy=0, done=0, error=0.
  - FSM to IDLE; internal candidate, divisor and remainder registers cleared.
- FSM states: IDLE, NEXT, TEST, DIV, DONE.
- IDLE/DONE + start=1:
  - Latch n; clear done, error, result and count.
  - If n==0: next state DONE with done=1, error=1, busy=0, result=0.
  - Otherwise: busy=1 next cycle, candidate c=2, go TEST.
- start while busy: ignored, no effect on any register.
- TEST:
  - c==2: prime immediately.
  - Odd c: d=3. If d*d > c, c is prime. Otherwise go DIV.
  - d*d is computed at 2*WIDTH bits; no wrap is permitted.
- DIV:
  - Restoring bit-serial remainder of c mod d, one quotient bit per cycle, exactly WIDTH cycles.
  - Remainder 0: c is composite, go NEXT.
  - Otherwise d=d+2, back to TEST. The d*d > c check comes first, so c itself is never used as a divisor.
- Prime found:
  - count increments the same cycle.
  - If count+1 == n_latched: result=c, done=1, busy=0, state DONE.
  - Otherwise go NEXT.
- NEXT candidate sequence: 2 -> 3 -> 5 -> 7 … Odd-only after 3; even candidates > 2 are never generated.
- Overflow:
  - Condition: the next candidate c+1 (from 2) or c+2 (odd c) exceeds 2^WIDTH-1. Computed at WIDTH+1 bits.
  - Response: done=1, error=1, busy=0, state DONE.
  - result = last prime found; count = primes found.
- Simultaneous accepted start and completion cannot occur: start is only sampled in IDLE/DONE.
- Outputs are registered; no combinational path from any input to any output.
- Run latency is not fixed.
  - Bench upper bound: total cycles ≤ (number of candidates tested) × (sqrt(c)/2+1) × (WIDTH+2) + 4.
  - Bench waits on done, never on a cycle count.

Test Plan:
- WIDTH=32, rst pulse, start with n=1:
  - Required: busy next cycle; then done=1, error=0, result=2, count=1.
- n=6: result=13, count=6, error=0. Then, without reset, start n=4: done drops the cycle after start, then result=7, count=4.
- n=10001 (WIDTH=32): result=104743, count=10001, error=0; done stays high until the next start.
- n=0: next cycle done=1, error=1, result=0, count=0, busy never asserted.
- WIDTH=8, n=55:
  - Required: done=1, error=1, result=251, count=54. 251 is the last 8-bit prime, so there is no wrap to small candidates.
  - Same WIDTH=8, n=54: result=251, error=0.
- Hazard and reset checks:
  - Start n=100; pulse start again mid-run with n=3: ignored, final result=541.
  - Rerun n=100; assert rst mid-run: all outputs read 0 immediately (asynchronously, before the next edge). Then start n=3: result=5.
